// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: read ports, write/writeback port, issue port
// and scoreboard status. Master is the pipeline side; slave is the register file.
interface register_file_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] crs;
    logic [DATA_W-1:0] crt;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] dw;
    logic              rwe;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_rd;
    logic              rs_busy;
    logic              rt_busy;
    logic [ADDR_W:0]   busy_cnt;
    logic              sb_full;

    modport master (
        output rs, rt, rw, dw, rwe, iss_en, iss_rd,
        input  crs, crt, rs_busy, rt_busy, busy_cnt, sb_full
    );

    modport slave (
        input  rs, rt, rw, dw, rwe, iss_en, iss_rd,
        output crs, crt, rs_busy, rt_busy, busy_cnt, sb_full
    );
endinterface

// File: rtl/register_file_sb.sv
// Parametrised 2-read/1-write register file with optional zero register, write
// bypass and registered reads, plus a per-register busy scoreboard and counter.
module register_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_READ = 0
) (
    input  logic               clk,
    input  logic               rst,
    register_file_sb_if.slave  bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH - ZERO_REG);
    localparam bit                ZR       = (ZERO_REG != 0);
    localparam bit                BP       = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic              wr_ok, iss_ok, cnt_inc, cnt_dec;
    logic [DATA_W-1:0] crs_d, crt_d;

    // Writes and issues that target the hardwired zero register are dropped.
    always_comb begin
        wr_ok  = bus.rwe && !(ZR && bus.rw == '0);
        iss_ok = bus.iss_en && !(ZR && bus.iss_rd == '0);
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) mem_d[bus.rw] = bus.dw;
    end

    // Issue is applied after writeback so a new producer supersedes the old one.
    always_comb begin
        busy_d = busy_q;
        if (bus.rwe) busy_d[bus.rw] = 1'b0;
        if (iss_ok)  busy_d[bus.iss_rd] = 1'b1;

        cnt_inc = iss_ok && !busy_q[bus.iss_rd];
        cnt_dec = bus.rwe && busy_q[bus.rw] && !(iss_ok && bus.iss_rd == bus.rw);

        busy_cnt_d = busy_cnt_q;
        if (cnt_inc && !cnt_dec)      busy_cnt_d = busy_cnt_q + CNT_W'(1);
        else if (cnt_dec && !cnt_inc) busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end

    always_comb begin
        crs_d = mem_q[bus.rs];
        if (BP && wr_ok && bus.rw == bus.rs) crs_d = bus.dw;
        if (ZR && bus.rs == '0)              crs_d = '0;

        crt_d = mem_q[bus.rt];
        if (BP && wr_ok && bus.rw == bus.rt) crt_d = bus.dw;
        if (ZR && bus.rt == '0)              crt_d = '0;
    end

    // NOTE: the register array is reset because every register must read 0 out of reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // A same-cycle writeback hands the reader its data, so it no longer has to stall.
    assign bus.rs_busy  = busy_q[bus.rs] && !(BP && bus.rwe && bus.rw == bus.rs)
                          && !(ZR && bus.rs == '0);
    assign bus.rt_busy  = busy_q[bus.rt] && !(BP && bus.rwe && bus.rw == bus.rt)
                          && !(ZR && bus.rt == '0);
    assign bus.busy_cnt = busy_cnt_q;
    assign bus.sb_full  = (busy_cnt_q == FULL_CNT);

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [DATA_W-1:0] crs_q, crt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    crs_q <= '0;
                    crt_q <= '0;
                end else begin
                    crs_q <= crs_d;
                    crt_q <= crt_d;
                end
            end

            assign bus.crs = crs_q;
            assign bus.crt = crt_q;
        end else begin : g_comb_read
            assign bus.crs = crs_d;
            assign bus.crt = crt_d;
        end
    endgenerate
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: three configurations (bypass, no bypass, registered read)
// driven in lockstep and compared against an array-based model of the register file.
module tb_register_file_sb;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk, rst;
    logic [ADDR_W-1:0] rs, rt, rw, iss_rd;
    logic [DATA_W-1:0] dw;
    logic              rwe, iss_en;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents, busy flags, registered-read captures.
    logic [DATA_W-1:0] mem_m [DEPTH];
    bit                busy_m [DEPTH];
    logic [DATA_W-1:0] rr_s, rr_t;

    register_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a ();
    register_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();
    register_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_c ();

    assign if_a.rs = rs;  assign if_a.rt = rt;  assign if_a.rw = rw;  assign if_a.dw = dw;
    assign if_a.rwe = rwe; assign if_a.iss_en = iss_en; assign if_a.iss_rd = iss_rd;
    assign if_b.rs = rs;  assign if_b.rt = rt;  assign if_b.rw = rw;  assign if_b.dw = dw;
    assign if_b.rwe = rwe; assign if_b.iss_en = iss_en; assign if_b.iss_rd = iss_rd;
    assign if_c.rs = rs;  assign if_c.rt = rt;  assign if_c.rw = rw;  assign if_c.dw = dw;
    assign if_c.rwe = rwe; assign if_c.iss_en = iss_en; assign if_c.iss_rd = iss_rd;

    register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1), .REG_READ(0))
        u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0), .REG_READ(0))
        u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1), .REG_READ(1))
        u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && rwe && rw == a) return dw;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && rwe && rw == a) return 1'b0;
        return busy_m[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(busy_m[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
        rr_s = '0;
        rr_t = '0;
    endtask

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_edge();
        if (rst) return;
        rr_s = exp_read(rs, 1'b1);
        rr_t = exp_read(rt, 1'b1);
        if (rwe) begin
            busy_m[rw] = 1'b0;
            if (rw != 0) mem_m[rw] = dw;
        end
        if (iss_en && iss_rd != 0) busy_m[iss_rd] = 1'b1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, " a.crs"}, 32'(if_a.crs), 32'(exp_read(rs, 1'b1)));
        check({tag, " a.crt"}, 32'(if_a.crt), 32'(exp_read(rt, 1'b1)));
        check({tag, " b.crs"}, 32'(if_b.crs), 32'(exp_read(rs, 1'b0)));
        check({tag, " b.crt"}, 32'(if_b.crt), 32'(exp_read(rt, 1'b0)));
        check({tag, " c.crs"}, 32'(if_c.crs), 32'(rr_s));
        check({tag, " c.crt"}, 32'(if_c.crt), 32'(rr_t));
        check({tag, " a.rs_busy"}, 32'(if_a.rs_busy), 32'(exp_busy(rs, 1'b1)));
        check({tag, " a.rt_busy"}, 32'(if_a.rt_busy), 32'(exp_busy(rt, 1'b1)));
        check({tag, " b.rs_busy"}, 32'(if_b.rs_busy), 32'(exp_busy(rs, 1'b0)));
        check({tag, " c.rt_busy"}, 32'(if_c.rt_busy), 32'(exp_busy(rt, 1'b1)));
        check({tag, " a.busy_cnt"}, 32'(if_a.busy_cnt), 32'(exp_cnt()));
        check({tag, " b.busy_cnt"}, 32'(if_b.busy_cnt), 32'(exp_cnt()));
        check({tag, " c.busy_cnt"}, 32'(if_c.busy_cnt), 32'(exp_cnt()));
        check({tag, " a.sb_full"}, 32'(if_a.sb_full), 32'(exp_cnt() == DEPTH - 1));
    endtask

    initial begin
        rst = 1'b1;
        rs = 3'd0; rt = 3'd7; rw = '0; dw = '0; rwe = 1'b0; iss_en = 1'b0; iss_rd = '0;
        model_reset();
        #1;
        check_all("reset");
        check("reset crs", 32'(if_a.crs), 32'h0);
        check("reset crt", 32'(if_a.crt), 32'h0);
        check("reset cnt", 32'(if_a.busy_cnt), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        // Plain write, dual read of the same address, dropped write to register 0.
        rwe = 1'b1; rw = 3'd5; dw = 8'hA5;
        #1; check_all("wr5");
        tick();
        rwe = 1'b0; rs = 3'd5; rt = 3'd5;
        #1; check_all("rd5");
        check("rd5 crs", 32'(if_a.crs), 32'hA5);
        check("rd5 crt", 32'(if_a.crt), 32'hA5);
        rwe = 1'b1; rw = 3'd0; dw = 8'hFF;
        tick();
        rwe = 1'b0; rs = 3'd0;
        #1; check_all("rd0");
        check("rd0 crs", 32'(if_a.crs), 32'h0);

        // Bypass versus no bypass on a same-cycle write.
        rwe = 1'b1; rw = 3'd3; dw = 8'h11;
        tick();
        dw = 8'h22; rs = 3'd3;
        #1; check_all("byp");
        check("byp a.crs", 32'(if_a.crs), 32'h22);
        check("byp b.crs", 32'(if_b.crs), 32'h11);
        tick();
        rwe = 1'b0;
        #1; check_all("byp post");
        check("byp post a.crs", 32'(if_a.crs), 32'h22);
        check("byp post b.crs", 32'(if_b.crs), 32'h22);

        // Registered read latency and write-first capture.
        rwe = 1'b1; rw = 3'd2; dw = 8'h3C; rs = 3'd0;
        tick();
        rwe = 1'b0; rs = 3'd2;
        #1; check_all("rr pres");
        tick();
        check_all("rr lat");
        check("rr lat c.crs", 32'(if_c.crs), 32'h3C);
        rwe = 1'b1; rw = 3'd2; dw = 8'h5A;
        #1; check_all("rr wf pre");
        tick();
        rwe = 1'b0;
        #1; check_all("rr wf");
        check("rr wf c.crs", 32'(if_c.crs), 32'h5A);

        // Scoreboard: issue, issue+writeback collision, lone writeback.
        iss_en = 1'b1; iss_rd = 3'd4;
        tick();
        iss_en = 1'b0; rs = 3'd4;
        #1; check_all("sb iss");
        check("sb iss busy", 32'(if_a.rs_busy), 32'h1);
        check("sb iss cnt", 32'(if_a.busy_cnt), 32'h1);
        iss_en = 1'b1; iss_rd = 3'd4; rwe = 1'b1; rw = 3'd4; dw = 8'h44;
        tick();
        iss_en = 1'b0; rwe = 1'b0;
        #1; check_all("sb coll");
        check("sb coll busy", 32'(if_a.rs_busy), 32'h1);
        check("sb coll cnt", 32'(if_a.busy_cnt), 32'h1);
        rwe = 1'b1; rw = 3'd4; dw = 8'h45;
        #1; check_all("sb wb");
        check("sb wb a.busy", 32'(if_a.rs_busy), 32'h0);
        check("sb wb b.busy", 32'(if_b.rs_busy), 32'h1);
        tick();
        rwe = 1'b0;
        #1; check_all("sb wb post");
        check("sb wb post cnt", 32'(if_a.busy_cnt), 32'h0);

        // Mid-cycle reset with three registers pending.
        for (int r = 1; r <= 3; r++) begin
            iss_en = 1'b1; iss_rd = 3'(r);
            tick();
        end
        iss_en = 1'b0; rs = 3'd5; rt = 3'd2;
        #1; check("pre rst cnt", 32'(if_a.busy_cnt), 32'h3);
        #1; rst = 1'b1;
        model_reset();
        #1; check_all("async rst");
        check("async rst cnt", 32'(if_a.busy_cnt), 32'h0);
        check("async rst crs", 32'(if_a.crs), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        // Fill the scoreboard, then a dropped issue to register 0 and one writeback.
        for (int r = 1; r <= 7; r++) begin
            iss_en = 1'b1; iss_rd = 3'(r);
            tick();
        end
        iss_en = 1'b0;
        #1; check_all("fill");
        check("fill cnt", 32'(if_a.busy_cnt), 32'h7);
        check("fill full", 32'(if_a.sb_full), 32'h1);
        iss_en = 1'b1; iss_rd = 3'd0;
        tick();
        iss_en = 1'b0;
        check("iss0 cnt", 32'(if_a.busy_cnt), 32'h7);
        rwe = 1'b1; rw = 3'd6; dw = 8'h66;
        tick();
        rwe = 1'b0;
        #1; check_all("wb6");
        check("wb6 cnt", 32'(if_a.busy_cnt), 32'h6);
        check("wb6 full", 32'(if_a.sb_full), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rs     = 3'($urandom_range(0, DEPTH - 1));
            rt     = 3'($urandom_range(0, DEPTH - 1));
            rw     = 3'($urandom_range(0, DEPTH - 1));
            dw     = 8'($urandom);
            rwe    = 1'($urandom_range(0, 1));
            iss_en = 1'($urandom_range(0, 1));
            iss_rd = 3'($urandom_range(0, DEPTH - 1));
            #1; check_all("rnd");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the team's 4x4-bit, 2-read/1-write register file.
- Generalises data width and depth, and adds an optional hardwired-zero register 0, same-cycle write-to-read bypass and an optional registered-read mode.
- Adds a per-register busy scoreboard with an occupancy counter, so the datapath can stall on pending writebacks.
- Sits between decode (issue/read) and writeback in the team's pipelined CPU exercises.

Parameters:
- DATA_W, 8, width of each register.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read port.
- REG_READ, 0, 0 = combinational read; 1 = read outputs registered (1-cycle latency).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rs  in  ADDR_W  read address, port S.
- rt  in  ADDR_W  read address, port T.
- crs  out  DATA_W  read data, port S.
- crt  out  DATA_W  read data, port T.
- rw  in  ADDR_W  write address.
- dw  in  DATA_W  write data.
- rwe  in  1  write enable; also the writeback that clears busy[rw].
- iss_en  in  1  issue strobe; sets busy[iss_rd].
- iss_rd  in  ADDR_W  destination register of the issuing instruction.
- rs_busy  out  1  register rs has a pending write.
- rt_busy  out  1  register rt has a pending write.
- busy_cnt  out  ADDR_W+1  number of busy registers.
- sb_full  out  1  busy_cnt == number of writable registers.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - While rst=1, all registers = 0, all busy bits = 0 and busy_cnt = 0.
  - In REG_READ=1 mode, the crs/crt output registers also = 0.
  - Reset asserted mid-operation discards every pending write and clears the scoreboard immediately, without waiting for clk.
- Write:
  - On a clk rising edge with rwe=1, mem[rw] <= dw.
  - When ZERO_REG=1 and rw=0, the write is dropped.
- Read, REG_READ=0:
  - crs = mem[rs], combinational.
  - If BYPASS=1, rwe=1, rw==rs and the write is not dropped, crs = dw instead.
  - If ZERO_REG=1 and rs=0, crs = 0 regardless of bypass.
  - Port T follows the same rules with rt/crt.
- Read, REG_READ=1:
  - crs/crt are captured on the rising edge, write-first.
  - The value captured equals what REG_READ=0 would show just before that edge.
  - Data is therefore valid one cycle after the address is presented.
  - rs_busy/rt_busy stay combinational in both modes.
- Scoreboard update per edge:
  - Clear: if rwe=1, busy[rw] <= 0.
  - Set: if iss_en=1, busy[iss_rd] <= 1.
  - When iss_rd == rw in the same cycle, set wins; the new producer supersedes the writeback.
  - With ZERO_REG=1, register 0 is never set.
  - iss_en to an already busy register keeps it busy; busy_cnt does not change.
  - rwe to a non-busy register writes data only; busy_cnt does not change.
- Busy outputs:
  - rs_busy = busy[rs], masked to 0 when BYPASS=1 and the same-cycle writeback (rwe, rw==rs) is clearing it.
  - rt_busy follows the same rule with rt.
  - Both are 0 for register 0 when ZERO_REG=1.
- busy_cnt: registered counter, updated on the same edge as the busy bits.
  - Net change per cycle is +1, 0 or -1, from the actual bit transitions only.
  - Range 0 .. 2**ADDR_W - ZERO_REG; never wraps.
  - sb_full = (busy_cnt == 2**ADDR_W - ZERO_REG).
- Both read ports may use the same address; each returns the same value.

Test Plan:
1. Reset, then rs=0, rt=7 -> crs=0, crt=0, busy_cnt=0; assert rst mid-run with busy_cnt=3 -> busy_cnt=0 and all reads 0 before the next clk edge.
2. Write rw=5, dw=8'hA5, rwe=1 for one edge, then rs=5, rt=5 -> crs=crt=8'hA5; write rw=0, dw=8'hFF (ZERO_REG=1) -> rs=0 reads 0.
3. Bypass: mem[3]=8'h11; same cycle rwe=1, rw=3, dw=8'h22, rs=3 -> crs=8'h22 before the edge (BYPASS=1), 8'h11 with BYPASS=0; crs=8'h22 after the edge in both cases.
4. REG_READ=1: mem[2]=8'h3C, present rs=2 -> crs=8'h3C only after the next edge; write rw=2, dw=8'h5A on that edge with rs=2 -> crs=8'h5A.
5. Scoreboard:
   - Issue iss_rd=4 -> rs=4 gives rs_busy=1, busy_cnt=1.
   - Same cycle iss_rd=4 and rwe, rw=4 -> stays busy, busy_cnt=1.
   - Writeback alone, rw=4 -> rs_busy=0 during that cycle (BYPASS=1), busy_cnt=0 after.
6. Fill: issue registers 1..7 on consecutive cycles -> busy_cnt=7, sb_full=1; issue 0 -> no change; one writeback rw=6 -> busy_cnt=6, sb_full=0.
